compare_flag_unit: RTL

COMPARE_FLAG_UNIT -- requirements
Module: compare_flag_unit

---
 rtl/compare_flag_unit_pkg.sv | 13 +
 rtl/compare_flag_unit_chunk_adder.sv | 20 ++
 rtl/compare_flag_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/compare_flag_unit_pkg.sv
// Shared types and default sizing for the multi-cycle compare/flag unit.
package compare_flag_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

endpackage

// File: rtl/compare_flag_unit_chunk_adder.sv
// One CHUNK-bit slice of a + ~b + cin; the caller supplies b already inverted.
module chunk_adder
    import compare_flag_unit_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_n_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    logic [CHUNK:0] total;

    assign total  = {1'b0, a_i} + {1'b0, b_n_i} + {{CHUNK{1'b0}}, cin_i};
    assign sum_o  = total[CHUNK-1:0];
    assign cout_o = total[CHUNK];

endmodule

// File: rtl/compare_flag_unit.sv
// Chunk-serial subtractor producing op_a - op_b with zero/carry/overflow/sign flags,
// one CHUNK-bit slice per cycle, fixed latency of WIDTH/CHUNK cycles.
module compare_flag_unit
    import compare_flag_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zeroSignal,
    output logic             carrySignal,
    output logic             overflowSignal,
    output logic             signSignal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("compare_flag_unit: WIDTH must be a positive multiple of CHUNK");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               zacc_q, zacc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               cflag_q, cflag_d;
    logic               ovf_q, ovf_d;
    logic               sign_q, sign_d;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk_n;
    logic [CHUNK-1:0]   sum_chunk;
    logic               chunk_cout;
    logic               chunk_zero;
    logic               accept;

    assign a_chunk    = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign b_chunk_n  = ~b_q[int'(idx_q) * CHUNK +: CHUNK];
    assign chunk_zero = (sum_chunk == '0);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i    (a_chunk),
        .b_n_i  (b_chunk_n),
        .cin_i  (carry_q),
        .sum_o  (sum_chunk),
        .cout_o (chunk_cout)
    );

    // A new request is taken in IDLE or in the DONE cycle, never mid-operation.
    assign accept = start && (state_q != ST_RUN);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
        cflag_d  = cflag_q;
        ovf_d    = ovf_q;
        sign_d   = sign_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[int'(idx_q) * CHUNK +: CHUNK] = sum_chunk;
                carry_d = chunk_cout;
                zacc_d  = zacc_q & chunk_zero;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    zero_d  = zacc_q & chunk_zero;
                    cflag_d = chunk_cout;
                    sign_d  = sum_chunk[CHUNK-1];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (sum_chunk[CHUNK-1] != a_q[WIDTH-1]);
                end
            end
            ST_DONE: begin
                state_d = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            a_d     = op_a;
            b_d     = op_b;
            idx_d   = '0;
            carry_d = 1'b1;
            zacc_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cflag_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cflag_q  <= cflag_d;
            ovf_q    <= ovf_d;
            sign_q   <= sign_d;
        end
    end

    // Operand latches are pure data; they are always reloaded before use.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign result         = result_q;
    assign zeroSignal     = zero_q;
    assign carrySignal    = cflag_q;
    assign overflowSignal = ovf_q;
    assign signSignal     = sign_q;

endmodule
